// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/LEN/3-byte instruction frames from a
// host receiver and writes 18-bit instructions into the program BRAM port A.
module prog_loader #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [17:0]           mem_instruction,
    output logic [3:0]            mem_we,
    output logic                  proc_reset,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

    state_t                  state_q;
    logic                    rx_ready_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [17:0]             instr_q;
    logic [3:0]              we_q;
    logic                    proc_reset_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic [15:0]             len_q;
    logic [16:0]             wr_cnt_q;
    logic [7:0]              sum_q;
    logic [TW-1:0]           timer_q;
    logic [1:0]              b0_q;
    logic [7:0]              b1_q;

    logic                    accept;
    logic                    in_frame;
    logic                    timeout_hit;
    logic [15:0]             len_d;
    logic [7:0]              sum_d;

    assign accept      = rx_valid && rx_ready_q;
    assign in_frame    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign len_d       = {len_q[15:8], rx_data};
    assign sum_d       = sum_q + rx_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rx_ready_q   <= 1'b1;
            addr_q       <= '0;
            instr_q      <= '0;
            we_q         <= '0;
            proc_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            len_q        <= '0;
            wr_cnt_q     <= '0;
            sum_q        <= '0;
            timer_q      <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
        end else begin
            we_q       <= '0;
            rx_ready_q <= 1'b1;
            if (!in_frame || accept) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
            if (accept) begin
                sum_q <= sum_d;
            end

            case (state_q)
                // DONE/ERR last one cycle and treat their byte like an IDLE byte
                S_IDLE, S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    if (accept && rx_data == SYNC_BYTE) begin
                        state_q      <= S_LEN_H;
                        proc_reset_q <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        sum_q        <= '0;
                        addr_q       <= '0;
                        wr_cnt_q     <= '0;
                    end
                end
                S_LEN_H: begin
                    if (accept) begin
                        len_q[15:8] <= rx_data;
                        state_q     <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (accept) begin
                        len_q[7:0] <= rx_data;
                        if (len_d == '0 || {1'b0, len_d} > DEPTH) begin
                            state_q <= S_ERR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_B0;
                        end
                    end
                end
                S_B0: begin
                    if (accept) begin
                        if (rx_data[7:2] != '0) begin
                            state_q <= S_ERR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            b0_q    <= rx_data[1:0];
                            state_q <= S_B1;
                        end
                    end
                end
                S_B1: begin
                    if (accept) begin
                        b1_q    <= rx_data;
                        state_q <= S_B2;
                    end
                end
                S_B2: begin
                    if (accept) begin
                        instr_q    <= {b0_q, b1_q, rx_data};
                        we_q       <= '1;
                        rx_ready_q <= 1'b0;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_q   <= addr_q + ADDR_WIDTH'(1);
                    wr_cnt_q <= wr_cnt_q + 17'd1;
                    if (wr_cnt_q + 17'd1 == {1'b0, len_q}) begin
                        state_q <= S_CSUM;
                    end else begin
                        state_q <= S_B0;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (sum_d == '0) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            proc_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Timeout overrides whatever the frame state decided this cycle
            if (in_frame && !accept && timeout_hit) begin
                state_q <= S_ERR;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
            end
        end
    end

    assign rx_ready        = rx_ready_q;
    assign mem_address     = addr_q;
    assign mem_instruction = instr_q;
    assign mem_we          = we_q;
    assign proc_reset      = proc_reset_q;
    assign load_busy       = busy_q;
    assign load_done       = done_q;
    assign load_error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level parser model predicts writes
// and frame outcomes; a monitor compares them as the DUT presents them.
module tb_prog_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned T     = 64;
    localparam logic [7:0]  SYNC  = 8'hA5;

    typedef logic [7:0] u8_t;
    typedef u8_t bq_t[$];
    typedef struct {
        logic [AW-1:0] addr;
        logic [17:0]   instr;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AW-1:0] mem_address;
    logic [17:0]   mem_instruction;
    logic [3:0]    mem_we;
    logic          proc_reset, load_busy, load_done, load_error;

    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;
    wr_t exp_wr[$];
    bit  exp_out[$];

    prog_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_address(mem_address), .mem_instruction(mem_instruction),
        .mem_we(mem_we), .proc_reset(proc_reset), .load_busy(load_busy),
        .load_done(load_done), .load_error(load_error)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: scan for SYNC, apply length/B0/checksum rules,
    // a frame cut short by the end of the stream ends in a timeout error.
    task automatic model_stream(input bq_t s);
        int unsigned i, n;
        logic [7:0]  sum;
        bit          bad;
        wr_t         w;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != SYNC) begin i++; continue; end
            i++;
            if (i + 2 > s.size()) begin exp_out.push_back(1'b0); return; end
            n   = 32'({s[i], s[i+1]});
            sum = s[i] + s[i+1];
            i  += 2;
            if (n == 0 || n > DEPTH) begin exp_out.push_back(1'b0); continue; end
            bad = 1'b0;
            for (int unsigned k = 0; k < n; k++) begin
                if (i >= s.size()) begin exp_out.push_back(1'b0); return; end
                if (s[i][7:2] != 6'd0) begin bad = 1'b1; i++; break; end
                if (i + 3 > s.size()) begin exp_out.push_back(1'b0); return; end
                w.addr  = AW'(k % DEPTH);
                w.instr = {s[i][1:0], s[i+1], s[i+2]};
                exp_wr.push_back(w);
                sum = sum + s[i] + s[i+1] + s[i+2];
                i  += 3;
            end
            if (bad) begin exp_out.push_back(1'b0); continue; end
            if (i >= s.size()) begin exp_out.push_back(1'b0); return; end
            sum = sum + s[i];
            i++;
            exp_out.push_back(sum == 8'h00);
        end
    endtask

    task automatic build_frame(input int unsigned n, input logic [15:0] len, input int bad_idx,
                               input logic [7:0] cdelta, output bq_t q);
        logic [17:0] ins;
        logic [7:0]  sum, b0;
        q = {};
        q.push_back(SYNC);
        q.push_back(len[15:8]);
        q.push_back(len[7:0]);
        sum = len[15:8] + len[7:0];
        for (int unsigned k = 0; k < n; k++) begin
            ins = 18'($urandom);
            b0  = {6'd0, ins[17:16]};
            if (int'(k) == bad_idx) b0[7:2] = 6'($urandom_range(1, 63));
            q.push_back(b0);
            q.push_back(ins[15:8]);
            q.push_back(ins[7:0]);
            sum = sum + b0 + ins[15:8] + ins[7:0];
        end
        q.push_back(8'(8'h00 - sum) + cdelta);
    endtask

    task automatic send_byte(input u8_t b, input int unsigned gap);
        logic        rdy;
        int unsigned w;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        w = 0;
        forever begin
            rdy = rx_ready;
            @(posedge clk); #1;
            if (rdy) break;
            w++;
            if (w > 8) begin
                vectors++; miscompares++;
                $display("FAIL handshake: byte 0x%0h not accepted within 8 cycles", b);
                break;
            end
        end
    endtask

    task automatic send_stream(input bq_t s, input int unsigned maxgap);
        model_stream(s);
        foreach (s[i]) send_byte(s[i], $urandom_range(0, maxgap));
        rx_valid = 1'b0;
        repeat (T + 5) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_rx_ready", 32'(rx_ready), 1);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_mem_instruction", 32'(mem_instruction), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_proc_reset", 32'(proc_reset), 0);
        check("rst_load_busy", 32'(load_busy), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_load_error", 32'(load_error), 0);
    endtask

    // Monitor: writes and frame outcomes are popped as the DUT presents them
    initial begin
        bit  busy_prev = 1'b0;
        bit  rst_prev  = 1'b1;
        wr_t w;
        bit  ok;
        wait (mon_en);
        forever begin
            @(negedge clk);
            check("rx_ready_vs_write", 32'(rx_ready), 32'(mem_we == 4'b0000));
            if (mem_we !== 4'b0000) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", 32'(mem_address), 32'hFFFF_FFFF);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_we", 32'(mem_we), 32'hF);
                    check("wr_addr", 32'(mem_address), 32'(w.addr));
                    check("wr_instr", 32'(mem_instruction), 32'(w.instr));
                end
            end
            if (busy_prev && !load_busy && !rst_prev) begin
                if (exp_out.size() == 0) begin
                    check("unexpected_frame_end", 32'(load_busy), 1);
                end else begin
                    ok = exp_out.pop_front();
                    check("out_done", 32'(load_done), 32'(ok));
                    check("out_error", 32'(load_error), 32'(!ok));
                    check("out_proc_reset", 32'(proc_reset), 32'(!ok));
                end
            end
            busy_prev = load_busy;
            rst_prev  = reset;
        end
    end

    initial begin
        bq_t         s, f;
        int unsigned n, kind;
        int          bad;
        logic [15:0] len;
        logic [7:0]  cd, g;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset  = 1'b0;
        mon_en = 1'b1;

        s = {8'hA5, 8'h00, 8'h01, 8'h03, 8'h12, 8'h34, 8'hB6};
        send_stream(s, 0);
        check("first_done", 32'(load_done), 1);
        check("first_proc_reset", 32'(proc_reset), 0);
        check("first_instr_held", 32'(mem_instruction), 32'h31234);

        build_frame(3, 16'd3, -1, 8'd0, f);
        send_stream(f, 2);
        build_frame(3, 16'd3, -1, 8'd1, f);
        send_stream(f, 2);
        check("badsum_error", 32'(load_error), 1);
        check("badsum_done", 32'(load_done), 0);
        check("badsum_proc_reset", 32'(proc_reset), 1);
        build_frame(3, 16'd3, -1, 8'd0, f);
        send_stream(f, 1);
        check("recover_error", 32'(load_error), 0);
        check("recover_proc_reset", 32'(proc_reset), 0);

        s = {8'hA5, 8'h00, 8'h00};
        send_stream(s, 0);
        check("len0_error", 32'(load_error), 1);
        s = {8'hA5, 8'h04, 8'h01, 8'h00, 8'h11, 8'h22};
        send_stream(s, 0);
        check("len401_error", 32'(load_error), 1);
        s = {8'hA5, 8'h00, 8'h01, 8'h04, 8'h12, 8'h34, 8'h00};
        send_stream(s, 0);
        check("badb0_error", 32'(load_error), 1);

        // Exact stall of T cycles after LEN_L
        s = {8'hA5, 8'h00, 8'h01};
        model_stream(s);
        foreach (s[i]) send_byte(s[i], 0);
        rx_valid = 1'b0;
        repeat (T - 1) @(posedge clk);
        #1;
        check("stall_T-1_busy", 32'(load_busy), 1);
        check("stall_T-1_error", 32'(load_error), 0);
        @(posedge clk); #1;
        check("stall_T_error", 32'(load_error), 1);
        check("stall_T_busy", 32'(load_busy), 0);
        repeat (4) @(posedge clk);
        #1;

        // Stall of T-1 then continue
        s = {8'hA5, 8'h00, 8'h01, 8'h03, 8'h12, 8'h34, 8'hB6};
        model_stream(s);
        for (int i = 0; i < 7; i++) send_byte(s[i], (i == 3) ? T - 1 : 0);
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stall_ok_error", 32'(load_error), 0);
        check("stall_ok_done", 32'(load_done), 1);

        s = {8'h00, 8'hFF, 8'h5A};
        build_frame(2, 16'd2, -1, 8'd0, f);
        foreach (f[i]) s.push_back(f[i]);
        send_stream(s, 1);
        check("garbage_done", 32'(load_done), 1);

        // Reset while waiting for B1
        s = {8'hA5, 8'h00, 8'h02, 8'h03};
        foreach (s[i]) send_byte(s[i], 0);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values();
        reset = 1'b0;
        build_frame(2, 16'd2, -1, 8'd0, f);
        send_stream(f, 1);
        check("after_reset_done", 32'(load_done), 1);

        for (int it = 0; it < 20; it++) begin
            n    = $urandom_range(1, 6);
            kind = $urandom_range(0, 5);
            len  = 16'(n);
            bad  = -1;
            cd   = 8'd0;
            case (kind)
                3: cd = 8'($urandom_range(1, 255));
                4: bad = int'($urandom_range(0, n - 1));
                5: len = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'(32'h401 + $urandom_range(0, 100));
                default: ;
            endcase
            build_frame(n, len, bad, cd, f);
            s = {};
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == SYNC) g = 8'h00;
                s.push_back(g);
            end
            foreach (f[i]) s.push_back(f[i]);
            send_stream(s, 3);
        end

        for (int w = 0; w < 200 && (exp_wr.size() != 0 || exp_out.size() != 0); w++) @(posedge clk);
        #1;
        check("writes_left", 32'(exp_wr.size()), 0);
        check("outcomes_left", 32'(exp_out.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
